// File: rtl/dmi_sysbus_bridge.sv
// DMI register slave that turns debugger accesses into single-beat system-bus
// requests, with response timeout, sticky error reporting and address auto-increment.
//
// state  | meaning
// S_IDLE | no bus operation outstanding; new triggers accepted when err == 00
// S_REQ  | req_valid high, waiting for req_ready
// S_WAIT | request accepted, waiting for rsp_valid
module dmi_sysbus_bridge #(
   parameter logic [6:0]  BASE_ADDR      = 7'h60,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_en,
   input  logic        reg_wr_en,
   input  logic [6:0]  reg_wr_addr,
   input  logic [31:0] reg_wr_data,
   output logic [31:0] rd_data,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_write,
   output logic [31:0] req_addr,
   output logic [31:0] req_wdata,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_rdata,
   input  logic        rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   // Counter value seen on the last cycle before a timeout is declared
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [31:0] r_sbaddr;
   logic [31:0] r_sbdata;
   logic [1:0]  r_err;
   logic        r_autoinc;
   logic [31:0] r_rd_data;
   logic        r_req_valid;
   logic        r_req_write;
   logic [31:0] r_req_addr;
   logic [31:0] r_req_wdata;

   logic        w_sel_addr;
   logic        w_sel_data;
   logic        w_sel_cs;
   logic        w_busy;
   logic        w_go_wr;
   logic        w_go_rd;
   logic        w_trig;
   logic        w_accept;
   logic        w_viol;
   logic [31:0] w_sbcs;
   logic [31:0] w_rd_mux;

   assign w_sel_addr = reg_en && (reg_wr_addr == BASE_ADDR);
   assign w_sel_data = reg_en && (reg_wr_addr == BASE_ADDR + 7'd1);
   assign w_sel_cs   = reg_en && (reg_wr_addr == BASE_ADDR + 7'd2);
   assign w_busy     = (r_state != S_IDLE);
   assign w_go_wr    = w_sel_data && reg_wr_en;
   assign w_go_rd    = w_sel_cs && reg_wr_en && reg_wr_data[1];
   assign w_trig     = w_go_wr || w_go_rd;
   assign w_accept   = w_trig && !w_busy && (r_err == 2'b00);
   assign w_viol     = w_busy && (w_trig || (w_sel_addr && reg_wr_en));
   assign w_sbcs     = {27'd0, r_autoinc, r_err, 1'b0, w_busy};

   always_comb begin
      w_rd_mux = 32'd0;
      if (w_sel_addr)      w_rd_mux = r_sbaddr;
      else if (w_sel_data) w_rd_mux = r_sbdata;
      else if (w_sel_cs)   w_rd_mux = w_sbcs;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 16'd0;
         r_sbaddr    <= 32'd0;
         r_sbdata    <= 32'd0;
         r_err       <= 2'b00;
         r_autoinc   <= 1'b0;
         r_rd_data   <= 32'd0;
         r_req_valid <= 1'b0;
         r_req_write <= 1'b0;
         r_req_addr  <= 32'd0;
         r_req_wdata <= 32'd0;
      end else begin
         if (reg_en && !reg_wr_en)
            r_rd_data <= w_rd_mux;
         if (w_sel_addr && reg_wr_en && !w_busy)
            r_sbaddr <= reg_wr_data;
         if (w_sel_cs && reg_wr_en) begin
            r_autoinc <= reg_wr_data[4];
            r_err     <= r_err & ~reg_wr_data[3:2];
         end
         // Later assignments override the W1C clear: a newly raised error wins
         if (w_viol && (r_err == 2'b00))
            r_err <= 2'b11;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_REQ;
                  r_cnt       <= 16'd0;
                  r_req_valid <= 1'b1;
                  r_req_write <= w_go_wr;
                  r_req_addr  <= r_sbaddr;
                  r_req_wdata <= w_go_wr ? reg_wr_data : r_sbdata;
                  if (w_go_wr)
                     r_sbdata <= reg_wr_data;
               end
            end
            S_REQ: begin
               if (r_cnt == TO_LAST) begin
                  r_state     <= S_IDLE;
                  r_req_valid <= 1'b0;
                  r_err       <= 2'b10;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
                  if (req_ready) begin
                     r_state     <= S_WAIT;
                     r_req_valid <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               if (rsp_valid) begin
                  r_state <= S_IDLE;
                  if (!r_req_write)
                     r_sbdata <= rsp_rdata;
                  if (rsp_err)
                     r_err <= 2'b01;
                  else if (r_autoinc)
                     r_sbaddr <= r_sbaddr + 32'd4;
               end else if (r_cnt == TO_LAST) begin
                  r_state <= S_IDLE;
                  r_err   <= 2'b10;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data   = r_rd_data;
   assign req_valid = r_req_valid;
   assign req_write = r_req_write;
   assign req_addr  = r_req_addr;
   assign req_wdata = r_req_wdata;

endmodule
